// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for the pipelined adder/subtractor.
interface pipelined_adder_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    // Producer/consumer side (drives operands, accepts results)
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    // Adder side
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit slice per stage,
// carry registered between stages, global stall on output back-pressure.
module pipelined_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    pipelined_adder_if.slave bus
);
    localparam int unsigned STAGES = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
    localparam int unsigned REMAIN = (CHUNK == 0) ? 1 : WIDTH % CHUNK;

    if (CHUNK == 0 || REMAIN != 0) begin : g_bad_param
        $error("pipelined_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    logic             w_adv;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c_eff;

    // Subtraction as A + ~B + 1, with the borrow-in folded into the carry
    assign w_b_eff = bus.sub ? ~bus.b : bus.b;
    assign w_c_eff = bus.cin ^ bus.sub;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned REM  = WIDTH - k * CHUNK;
        localparam int unsigned DONE = (k + 1) * CHUNK;

        logic [REM-1:0]   w_op_a;
        logic [REM-1:0]   w_op_b;
        logic             w_cin;
        logic             w_vin;
        logic [CHUNK-1:0] w_s;
        logic             w_c;
        logic [DONE-1:0]  w_sum_nxt;

        logic             r_valid;
        logic [DONE-1:0]  r_sum;
        logic             r_carry;

        // Stage inputs: the conditioned beat for stage 0, predecessor registers otherwise
        if (k == 0) begin : g_src
            assign w_op_a    = bus.a;
            assign w_op_b    = w_b_eff;
            assign w_cin     = w_c_eff;
            assign w_vin     = bus.in_valid;
            assign w_sum_nxt = w_s;
        end else begin : g_src
            assign w_op_a    = g_stage[k-1].g_ops.r_a;
            assign w_op_b    = g_stage[k-1].g_ops.r_b;
            assign w_cin     = g_stage[k-1].r_carry;
            assign w_vin     = g_stage[k-1].r_valid;
            assign w_sum_nxt = {w_s, g_stage[k-1].r_sum};
        end

        // Slice add: the lowest remaining slice of each operand sits at bit 0
        assign {w_c, w_s} = {1'b0, w_op_a[CHUNK-1:0]} + {1'b0, w_op_b[CHUNK-1:0]}
                          + (CHUNK + 1)'(w_cin);

        // Valid, accumulated lower result slices and slice carry
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_sum   <= '0;
                r_carry <= 1'b0;
            end else if (w_adv) begin
                r_valid <= w_vin;
                r_sum   <= w_sum_nxt;
                r_carry <= w_c;
            end
        end

        if (k < STAGES - 1) begin : g_ops
            logic [REM-CHUNK-1:0] r_a;
            logic [REM-CHUNK-1:0] r_b;

            // Delay line for the operand slices not yet added
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_op_a[REM-1:CHUNK];
                    r_b <= w_op_b[REM-1:CHUNK];
                end
            end
        end else begin : g_last
            logic w_c_msb;
            logic r_overflow;

            // Carry into the MSB recovered from the MSB sum bit and its operands
            assign w_c_msb = w_s[CHUNK-1] ^ w_op_a[CHUNK-1] ^ w_op_b[CHUNK-1];

            // Signed overflow registered alongside the final slice
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_overflow <= 1'b0;
                end else if (w_adv) begin
                    r_overflow <= w_c_msb ^ w_c;
                end
            end
        end
    end

    // Whole pipe advances whenever the output slot is empty or being drained
    assign w_adv        = ~g_stage[STAGES-1].r_valid | bus.out_ready;
    assign bus.in_ready = w_adv;

    assign bus.out_valid = g_stage[STAGES-1].r_valid;
    assign bus.sum       = g_stage[STAGES-1].r_sum;
    assign bus.cout      = g_stage[STAGES-1].r_carry;
    assign bus.overflow  = g_stage[STAGES-1].g_last.r_overflow;
endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and streaming checks of pipelined_adder at four WIDTH/CHUNK points.
module tb_pipelined_adder;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // Per-instance drive/observe arrays: 0=(16,4) 1=(8,8) 2=(32,4) 3=(12,3)
    logic        d_valid [4];
    logic [31:0] d_a     [4];
    logic [31:0] d_b     [4];
    logic        d_cin   [4];
    logic        d_sub   [4];
    logic        d_ordy  [4];
    logic [31:0] o_sum   [4];
    logic        o_cout  [4];
    logic        o_ovf   [4];
    logic        o_valid [4];
    logic        o_irdy  [4];

    pipelined_adder_if #(.WIDTH(16)) bus0 ();
    pipelined_adder_if #(.WIDTH(8))  bus1 ();
    pipelined_adder_if #(.WIDTH(32)) bus2 ();
    pipelined_adder_if #(.WIDTH(12)) bus3 ();

    pipelined_adder #(.WIDTH(16), .CHUNK(4)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    pipelined_adder #(.WIDTH(8),  .CHUNK(8)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    pipelined_adder #(.WIDTH(32), .CHUNK(4)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
    pipelined_adder #(.WIDTH(12), .CHUNK(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

    assign bus0.in_valid = d_valid[0]; assign bus0.a = d_a[0][15:0]; assign bus0.b = d_b[0][15:0];
    assign bus0.cin = d_cin[0]; assign bus0.sub = d_sub[0]; assign bus0.out_ready = d_ordy[0];
    assign o_sum[0] = 32'(bus0.sum); assign o_cout[0] = bus0.cout; assign o_ovf[0] = bus0.overflow;
    assign o_valid[0] = bus0.out_valid; assign o_irdy[0] = bus0.in_ready;

    assign bus1.in_valid = d_valid[1]; assign bus1.a = d_a[1][7:0]; assign bus1.b = d_b[1][7:0];
    assign bus1.cin = d_cin[1]; assign bus1.sub = d_sub[1]; assign bus1.out_ready = d_ordy[1];
    assign o_sum[1] = 32'(bus1.sum); assign o_cout[1] = bus1.cout; assign o_ovf[1] = bus1.overflow;
    assign o_valid[1] = bus1.out_valid; assign o_irdy[1] = bus1.in_ready;

    assign bus2.in_valid = d_valid[2]; assign bus2.a = d_a[2]; assign bus2.b = d_b[2];
    assign bus2.cin = d_cin[2]; assign bus2.sub = d_sub[2]; assign bus2.out_ready = d_ordy[2];
    assign o_sum[2] = bus2.sum; assign o_cout[2] = bus2.cout; assign o_ovf[2] = bus2.overflow;
    assign o_valid[2] = bus2.out_valid; assign o_irdy[2] = bus2.in_ready;

    assign bus3.in_valid = d_valid[3]; assign bus3.a = d_a[3][11:0]; assign bus3.b = d_b[3][11:0];
    assign bus3.cin = d_cin[3]; assign bus3.sub = d_sub[3]; assign bus3.out_ready = d_ordy[3];
    assign o_sum[3] = 32'(bus3.sum); assign o_cout[3] = bus3.cout; assign o_ovf[3] = bus3.overflow;
    assign o_valid[3] = bus3.out_valid; assign o_irdy[3] = bus3.in_ready;

    // Reference: full-width add of A, conditioned B and carry; returns {ovf, cout, sum}
    function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        logic [63:0] m, mlo, be, c, full, low;
        logic        co, ov;
        m    = (64'd1 << w) - 64'd1;
        mlo  = (64'd1 << (w - 1)) - 64'd1;
        be   = (sub ? ~{32'd0, b} : {32'd0, b}) & m;
        c    = 64'(cin ^ sub);
        full = ({32'd0, a} & m) + be + c;
        low  = ({32'd0, a} & mlo) + (be & mlo) + c;
        co   = full[w];
        ov   = low[w-1] ^ co;
        return {ov, co, 32'(full & m)};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (o_valid[0] !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", o_valid[0]); end
        n_cmp++; if (o_sum[0] !== 32'd0) begin n_err++; $display("FAIL reset_sum got=%h exp=0", o_sum[0]); end
        n_cmp++; if (o_cout[0] !== 1'b0) begin n_err++; $display("FAIL reset_cout got=%b exp=0", o_cout[0]); end
        n_cmp++; if (o_ovf[0] !== 1'b0) begin n_err++; $display("FAIL reset_overflow got=%b exp=0", o_ovf[0]); end
        n_cmp++; if (o_irdy[0] !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", o_irdy[0]); end
        for (int k = 1; k < 4; k++) begin
            n_cmp++; if (o_valid[k] !== 1'b0) begin n_err++; $display("FAIL reset_out_valid_inst%0d got=%b exp=0", k, o_valid[k]); end
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [15:0] va [5];
        logic [15:0] vb [5];
        logic        vc [5];
        logic        vs [5];
        logic [15:0] es [5];
        logic        ec [5];
        logic        eo [5];
        int          lat;
        va = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
        vb = '{16'h0FFF, 16'h0000, 16'h0001, 16'h0007, 16'h0001};
        vc = '{1'b1,     1'b1,     1'b0,     1'b0,     1'b0};
        vs = '{1'b0,     1'b0,     1'b0,     1'b1,     1'b1};
        es = '{16'h2234, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF};
        ec = '{1'b0,     1'b1,     1'b0,     1'b0,     1'b1};
        eo = '{1'b0,     1'b0,     1'b1,     1'b0,     1'b1};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            d_ordy[0] = 1'b1; d_valid[0] = 1'b1;
            d_a[0] = {16'h0, va[i]}; d_b[0] = {16'h0, vb[i]}; d_cin[0] = vc[i]; d_sub[0] = vs[i];
            @(negedge clk);
            d_valid[0] = 1'b0;
            lat = 1;
            while (o_valid[0] !== 1'b1 && lat < 12) begin
                @(negedge clk);
                lat++;
            end
            n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL directed%0d_latency got=%0d exp=4", i, lat); end
            n_cmp++; if (o_sum[0] !== {16'h0, es[i]}) begin n_err++; $display("FAIL directed%0d_sum got=%h exp=%h", i, o_sum[0], es[i]); end
            n_cmp++; if (o_cout[0] !== ec[i]) begin n_err++; $display("FAIL directed%0d_cout got=%b exp=%b", i, o_cout[0], ec[i]); end
            n_cmp++; if (o_ovf[0] !== eo[i]) begin n_err++; $display("FAIL directed%0d_overflow got=%b exp=%b", i, o_ovf[0], eo[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [33:0] q [$];
        logic [33:0] held, exp_v, got_v;
        logic        stall_prev, have_beat;
        int          sent, rcvd, guard;
        sent = 0; rcvd = 0; guard = 0; stall_prev = 1'b0; have_beat = 1'b0; held = '0;
        @(negedge clk);
        while (rcvd < 20 && guard < 400) begin
            got_v = {o_ovf[0], o_cout[0], o_sum[0]};
            if (stall_prev) begin
                n_cmp++; if (o_valid[0] !== 1'b1 || got_v !== held) begin
                    n_err++; $display("FAIL stall_hold got=%b/%h exp=1/%h", o_valid[0], got_v, held);
                end
            end
            if (!have_beat && sent < 20) begin
                d_a[0] = $urandom; d_b[0] = $urandom;
                d_cin[0] = 1'($urandom_range(0, 1)); d_sub[0] = 1'($urandom_range(0, 1));
                have_beat = 1'b1;
            end
            d_valid[0] = have_beat;
            d_ordy[0]  = ($urandom_range(0, 2) != 0);
            #1;
            n_cmp++; if (o_irdy[0] !== (~o_valid[0] | d_ordy[0])) begin
                n_err++; $display("FAIL in_ready_rule got=%b exp=%b", o_irdy[0], ~o_valid[0] | d_ordy[0]);
            end
            if (o_valid[0] && d_ordy[0]) begin
                if (q.size() == 0) begin
                    n_cmp++; n_err++; $display("FAIL stream_extra_beat got=%h exp=none", got_v);
                end else begin
                    exp_v = q.pop_front();
                    n_cmp++; if (got_v !== exp_v) begin n_err++; $display("FAIL stream_beat%0d got=%h exp=%h", rcvd, got_v, exp_v); end
                end
                rcvd++;
            end
            if (d_valid[0] && o_irdy[0]) begin
                q.push_back(model(16, d_a[0], d_b[0], d_cin[0], d_sub[0]));
                have_beat = 1'b0;
                sent++;
            end
            stall_prev = o_valid[0] & ~d_ordy[0];
            held = got_v;
            guard++;
            @(negedge clk);
        end
        n_cmp++; if (rcvd !== 20 || q.size() != 0) begin
            n_err++; $display("FAIL stream_count got=%0d pending=%0d exp=20 pending=0", rcvd, q.size());
        end
        d_valid[0] = 1'b0; d_ordy[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++; if (o_valid[0] !== 1'b0) begin n_err++; $display("FAIL stream_drain_idle got=%b exp=0", o_valid[0]); end
        end
    endtask

    task automatic test_reset_midstream();
        int lat;
        @(negedge clk);
        d_ordy[0] = 1'b1; d_cin[0] = 1'b0; d_sub[0] = 1'b0;
        d_valid[0] = 1'b1; d_a[0] = 32'h0000FFFF; d_b[0] = 32'h00000002;
        @(negedge clk); d_a[0] = 32'h00001111; d_b[0] = 32'h00002222;
        @(negedge clk); d_a[0] = 32'h00003333; d_b[0] = 32'h00004444;
        @(negedge clk); d_valid[0] = 1'b0;
        @(negedge clk);
        n_cmp++; if (o_valid[0] !== 1'b1 || o_sum[0] !== 32'h1 || o_cout[0] !== 1'b1) begin
            n_err++; $display("FAIL pre_reset_head got=%b/%h/%b exp=1/00000001/1", o_valid[0], o_sum[0], o_cout[0]);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (o_valid[0] !== 1'b0) begin n_err++; $display("FAIL async_reset_valid got=%b exp=0", o_valid[0]); end
        n_cmp++; if (o_sum[0] !== 32'd0) begin n_err++; $display("FAIL async_reset_sum got=%h exp=0", o_sum[0]); end
        n_cmp++; if (o_cout[0] !== 1'b0) begin n_err++; $display("FAIL async_reset_cout got=%b exp=0", o_cout[0]); end
        n_cmp++; if (o_ovf[0] !== 1'b0) begin n_err++; $display("FAIL async_reset_overflow got=%b exp=0", o_ovf[0]); end
        n_cmp++; if (o_irdy[0] !== 1'b1) begin n_err++; $display("FAIL async_reset_in_ready got=%b exp=1", o_irdy[0]); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_cmp++; if (o_valid[0] !== 1'b0) begin n_err++; $display("FAIL stale_beat got=%b exp=0", o_valid[0]); end
        end
        d_valid[0] = 1'b1; d_a[0] = 32'h0000ABCD; d_b[0] = 32'h00001111; d_sub[0] = 1'b1; d_cin[0] = 1'b1;
        @(negedge clk);
        d_valid[0] = 1'b0;
        lat = 1;
        while (o_valid[0] !== 1'b1 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL post_reset_latency got=%0d exp=4", lat); end
        n_cmp++; if ({o_ovf[0], o_cout[0], o_sum[0]} !== {1'b0, 1'b1, 32'h00009ABB}) begin
            n_err++; $display("FAIL post_reset_result got=%b/%b/%h exp=0/1/00009abb", o_ovf[0], o_cout[0], o_sum[0]);
        end
        d_sub[0] = 1'b0; d_cin[0] = 1'b0;
    endtask

    task automatic test_sweep(input int idx, input int w, input int stg);
        logic [33:0] q_v [$];
        int          q_t [$];
        logic [33:0] got_v, exp_v;
        int          sent, rcvd, guard, t_in;
        sent = 0; rcvd = 0; guard = 0;
        @(negedge clk);
        while (rcvd < 200 && guard < 3000) begin
            d_ordy[idx]  = 1'b1;
            d_valid[idx] = (sent < 200) && ($urandom_range(0, 3) != 0);
            d_a[idx] = $urandom; d_b[idx] = $urandom;
            d_cin[idx] = 1'($urandom_range(0, 1)); d_sub[idx] = 1'($urandom_range(0, 1));
            #1;
            if (o_valid[idx]) begin
                got_v = {o_ovf[idx], o_cout[idx], o_sum[idx]};
                if (q_v.size() == 0) begin
                    n_cmp++; n_err++; $display("FAIL sweep_w%0d_extra got=%h exp=none", w, got_v);
                end else begin
                    exp_v = q_v.pop_front();
                    t_in  = q_t.pop_front();
                    n_cmp++; if (got_v !== exp_v) begin n_err++; $display("FAIL sweep_w%0d_beat%0d got=%h exp=%h", w, rcvd, got_v, exp_v); end
                    n_cmp++; if (guard - t_in !== stg) begin n_err++; $display("FAIL sweep_w%0d_latency got=%0d exp=%0d", w, guard - t_in, stg); end
                end
                rcvd++;
            end
            if (d_valid[idx] && o_irdy[idx]) begin
                q_v.push_back(model(w, d_a[idx], d_b[idx], d_cin[idx], d_sub[idx]));
                q_t.push_back(guard);
                sent++;
            end
            guard++;
            @(negedge clk);
        end
        d_valid[idx] = 1'b0;
        n_cmp++; if (rcvd !== 200) begin n_err++; $display("FAIL sweep_w%0d_count got=%0d exp=200", w, rcvd); end
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d_valid[k] = 1'b0; d_a[k] = '0; d_b[k] = '0;
            d_cin[k] = 1'b0; d_sub[k] = 1'b0; d_ordy[k] = 1'b1;
        end
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midstream();
        test_sweep(1, 8, 1);
        test_sweep(2, 32, 8);
        test_sweep(3, 12, 4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
